i2s_receiver: RTL

I2S_RECEIVER -- requirements
Module: i2s_receiver

---
 rtl/i2s_pkg.sv | 22 ++
 rtl/i2s_pin_sync.sv | 36 +++
 rtl/i2s_receiver.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// i2s_pkg: widths, FSM state encoding and frame payload shared by the
// I2S receiver and transmitter.
package i2s_pkg;

  localparam int unsigned SAMPLE_WIDTH = 24;
  localparam int unsigned CNT_WIDTH    = 5;

  // Bit count of a fully captured sample
  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(SAMPLE_WIDTH);

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } i2s_state_e;

  typedef struct packed {
    logic [SAMPLE_WIDTH-1:0] left;
    logic [SAMPLE_WIDTH-1:0] right;
  } i2s_frame_t;

endpackage

// File: rtl/i2s_pin_sync.sv
// i2s_pin_sync: two-flop synchronizer for one asynchronous pin plus a
// rising-edge pulse derived from the synchronized history.
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   pin      asynchronous input pin
//   sync     synchronized level (registered)
//   rise_c   one-cycle pulse on a synchronized 0->1 transition (combinational)
module i2s_pin_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic sync,
  output logic rise_c
);

  logic meta_q;
  logic sync_q;
  logic hist_q;

  // Synchronizer chain and one flop of history for edge detect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      hist_q <= 1'b0;
    end else begin
      meta_q <= pin;
      sync_q <= meta_q;
      hist_q <= sync_q;
    end
  end

  assign sync   = sync_q;
  assign rise_c = sync_q & ~hist_q;

endmodule

// File: rtl/i2s_receiver.sv
// i2s_receiver: captures 24-bit left/right samples from an I2S stream
// (SGTL5000 DOUT) into the clk domain and presents them as a
// valid/ready frame.
//   clk        50 MHz system clock
//   reset_n    asynchronous active-low reset
//   SCLK       I2S bit clock (async)
//   LRCLK      I2S word select (async), 0 = left, 1 = right
//   SDATA      I2S serial data (async)
//   sample_l   left sample of the presented frame
//   sample_r   right sample of the presented frame
//   out_valid  a complete, unconsumed frame is presented
//   out_ready  consumer accepts the frame when out_valid=1
//   overrun    sticky: a completed frame was dropped
//   frame_err  sticky: a slot ended with fewer than 24 bits
//   clr_flags  synchronous clear of overrun and frame_err
module i2s_receiver
  import i2s_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    SCLK,
  input  logic                    LRCLK,
  input  logic                    SDATA,
  output logic [SAMPLE_WIDTH-1:0] sample_l,
  output logic [SAMPLE_WIDTH-1:0] sample_r,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overrun,
  output logic                    frame_err,
  input  logic                    clr_flags
);

  logic sclk_lvl_unused;
  logic sclk_rise;
  logic lr_s;
  logic lr_rise_unused;
  logic sd_s;
  logic sd_rise_unused;

  i2s_pin_sync u_sync_sclk (
    .clk     (clk),
    .reset_n (reset_n),
    .pin     (SCLK),
    .sync    (sclk_lvl_unused),
    .rise_c  (sclk_rise)
  );

  i2s_pin_sync u_sync_lrclk (
    .clk     (clk),
    .reset_n (reset_n),
    .pin     (LRCLK),
    .sync    (lr_s),
    .rise_c  (lr_rise_unused)
  );

  i2s_pin_sync u_sync_sdata (
    .clk     (clk),
    .reset_n (reset_n),
    .pin     (SDATA),
    .sync    (sd_s),
    .rise_c  (sd_rise_unused)
  );

  i2s_state_e              state_q, state_d;
  logic                    lr_prev_q;
  logic [CNT_WIDTH-1:0]    cnt_q;
  logic [SAMPLE_WIDTH-1:0] shift_q;
  logic [SAMPLE_WIDTH-1:0] left_hold_q;
  logic                    left_good_q, left_good_d;

  logic                    boundary_c;
  logic                    word_ok_c;
  logic [SAMPLE_WIDTH-1:0] word_c;
  logic                    latch_left_c;
  logic                    frame_done_c;
  logic                    slot_err_c;
  logic                    load_c;
  logic                    drop_c;
  i2s_frame_t              frame_c;

  assign boundary_c = sclk_rise & (lr_s ^ lr_prev_q);

  // With 24-bit slots the LSB arrives on the boundary bit of the next slot,
  // so a 23-bit count is completed by the bit sampled at the boundary.
  assign word_ok_c = (cnt_q == CNT_FULL) || (cnt_q == CNT_FULL - CNT_WIDTH'(1));
  assign word_c    = (cnt_q == CNT_FULL) ? shift_q
                                         : {shift_q[SAMPLE_WIDTH-2:0], sd_s};

  assign frame_c = '{left: left_hold_q, right: word_c};
  assign load_c  = frame_done_c & (~out_valid | out_ready);
  assign drop_c  = frame_done_c & out_valid & ~out_ready;

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_SYNC;
    else          state_q <= state_d;
  end

  // FSM next state and slot-end decisions
  always_comb begin
    state_d      = state_q;
    left_good_d  = left_good_q;
    latch_left_c = 1'b0;
    frame_done_c = 1'b0;
    slot_err_c   = 1'b0;
    case (state_q)
      ST_SYNC: begin
        if (boundary_c && !lr_s) state_d = ST_LEFT;
      end
      ST_LEFT: begin
        if (boundary_c) begin
          state_d = ST_RIGHT;
          if (word_ok_c) begin
            latch_left_c = 1'b1;
            left_good_d  = 1'b1;
          end else begin
            slot_err_c  = 1'b1;
            left_good_d = 1'b0;
          end
        end
      end
      ST_RIGHT: begin
        if (boundary_c) begin
          state_d = ST_LEFT;
          if (word_ok_c && left_good_q) frame_done_c = 1'b1;
          else                          slot_err_c   = 1'b1;
        end
      end
      default: state_d = ST_SYNC;
    endcase
  end

  // Bit capture: boundary bit restarts the count, data saturates at 24 bits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lr_prev_q   <= 1'b0;
      cnt_q       <= '0;
      shift_q     <= '0;
      left_hold_q <= '0;
      left_good_q <= 1'b0;
    end else begin
      if (sclk_rise) begin
        lr_prev_q <= lr_s;
        if (boundary_c) begin
          cnt_q <= '0;
        end else if (state_q != ST_SYNC && cnt_q != CNT_FULL) begin
          shift_q <= {shift_q[SAMPLE_WIDTH-2:0], sd_s};
          cnt_q   <= cnt_q + CNT_WIDTH'(1);
        end
      end
      if (latch_left_c) left_hold_q <= word_c;
      left_good_q <= left_good_d;
    end
  end

  // Output frame handshake and sticky flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_l  <= '0;
      sample_r  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (load_c) begin
        sample_l  <= frame_c.left;
        sample_r  <= frame_c.right;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (drop_c)         overrun <= 1'b1;
      else if (clr_flags) overrun <= 1'b0;
      if (slot_err_c)     frame_err <= 1'b1;
      else if (clr_flags) frame_err <= 1'b0;
    end
  end

endmodule
